sad_min_search: RTL and testbench
=================================

# sad_min_search

Downstream consumer of the 4x4 SAD array's registered 12-bit `mad` stream. It scans one full search window of candidate SADs arriving in raster order and tracks the minimum SAD and its position. At the end of the window it reports the best SAD and the signed motion vector with a one-cycle `done` pulse. It sits between the SAD array and the motion-vector writeback logic.

## Interface
- `RANGE`, 7: search range ±RANGE pixels in x and y; legal values 1..7; window is (2·RANGE+1)² candidates (225 at default).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a new window scan when idle.
- `mad_valid`  in  1  qualifies `mad`; high for one cycle per candidate.
- `mad`  in  12  candidate SAD from the SAD array, unsigned.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse; results valid on the same cycle and held until the next scan completes.
- `best_sad`  out  12  minimum SAD of the last completed window.
- `mv_x`  out  5  signed (two's complement) x offset of the best candidate, −RANGE..+RANGE.
- `mv_y`  out  5  signed y offset of the best candidate, −RANGE..+RANGE.

## Operation
- States: IDLE, SCAN.
- IDLE: `busy`=0. `mad_valid` is ignored. When `start`=1, the block clears its x/y counters to 0, enters SCAN, and `busy`=1 from the next cycle.
- SCAN: each cycle with `mad_valid`=1 consumes one candidate at the current (x,y) index.
  - x runs 0..2·RANGE, then wraps to 0 and y increments.
  - Cycles with `mad_valid`=0 are stalls. Counters and the running minimum hold.
- Compare rule:
  - The first candidate (x=0, y=0) is always loaded as the running best, so a value of 12'hFFF is still captured.
  - Later candidates replace the running best only if `mad` < running best (strict). On ties the earlier candidate in raster order wins.
- Last candidate (x=2·RANGE, y=2·RANGE) accepted:
  - Running best is compared/updated as usual.
  - Result registers are loaded with best_sad, mv_x = bx−RANGE and mv_y = by−RANGE, computed in 5-bit signed arithmetic.
  - `done` pulses.
  - State returns to IDLE.
- Result registers change only on scan completion. An aborted scan (via reset) never alters them except through the reset itself.
- `start` while in SCAN is ignored. `start` on the same cycle that `done` pulses is also ignored, because the state is still SCAN on that cycle.
- The running-best register is internal and is not visible on the outputs.

## Timing
- Reset values: `busy`=0, `done`=0, `best_sad`=12'hFFF, `mv_x`=0, `mv_y`=0. State is IDLE and all counters are 0.
- `rst` overrides everything on any cycle, including mid-scan. The partial scan is discarded with no `done`.
- `start` sampled at edge N: `busy`=1 after edge N. The first candidate can be accepted at edge N+1 (the cycle after `start`). `mad_valid` on the same cycle as `start` is ignored.
- The last candidate is sampled at edge M. After edge M, `done`=1, the outputs are updated and `busy`=0, all for exactly one cycle of `done`. Latency is 1 cycle from the last sample to the result.
- Minimum scan length with no stalls is (2·RANGE+1)² cycles of `mad_valid` plus 1 cycle.
- Widths:
  - mad / best_sad: 12 bits unsigned, no arithmetic beyond compare.
  - x/y counters: 4 bits.
  - Candidate index never exceeds 2·RANGE.

## Test plan
- Decreasing stream, RANGE=1, 9 candidates with mad = 900, 800, …, 100 back-to-back → `done` one cycle after the 9th sample. Expect best_sad=100, mv_x=+1, mv_y=+1, `busy` low on the same cycle.
- Tie / first-wins, RANGE=1: all mad=12'hFFF except candidates 3 and 7 both = 50 → best_sad=50, mv_x=−1, mv_y=0 (candidate 3 is x=0, y=1).
- All-max window, RANGE=7: 225 samples of 12'hFFF → best_sad=12'hFFF, mv_x=−7, mv_y=−7, proving the unconditional first-candidate load.
- Stalls, RANGE=2: 25 samples with random `mad_valid` gaps, minimum value 17 at x=4, y=0 → best_sad=17, mv_x=+2, mv_y=−2. `done` one cycle after the 25th valid sample, regardless of the number of stall cycles.
- Reset mid-scan: after a completed scan (best_sad=17), start a new scan and assert `rst` after 10 samples → outputs return to reset values and there is no `done`. A following full scan completes normally.
- Ignored inputs: pulse `start` at sample 5 of a scan, and drive `mad_valid`=1 with mad=0 while IDLE → the scan completes at the original sample count with the original result, and IDLE inputs do not affect the next result.

Source files
------------

// File: rtl/sad_min_search_if.sv
// Handshake bundle between the SAD array, the minimum-search block and the
// motion-vector writeback logic. The master side drives scan control and the
// candidate stream; the slave side (sad_min_search) returns status and results.
interface sad_min_search_if;
  logic              start;
  logic              mad_valid;
  logic [11:0]       mad;
  logic              busy;
  logic              done;
  logic [11:0]       best_sad;
  logic signed [4:0] mv_x;
  logic signed [4:0] mv_y;

  modport master (
    output start, mad_valid, mad,
    input  busy, done, best_sad, mv_x, mv_y
  );

  modport slave (
    input  start, mad_valid, mad,
    output busy, done, best_sad, mv_x, mv_y
  );
endinterface

// File: rtl/sad_min_search.sv
// Minimum-SAD search over one (2*RANGE+1)^2 candidate window arriving in
// raster order. Tracks the smallest SAD and its (x,y) index, then reports the
// best SAD and the signed motion vector with a one-cycle done pulse.
module sad_min_search #(
  parameter int RANGE = 7
) (
  input  logic            clk,
  input  logic            rst,
  sad_min_search_if.slave s_if
);

  localparam int                DATA_W = 12;
  localparam logic [3:0]        LAST   = 4'(2 * RANGE);
  localparam logic signed [4:0] OFFS   = 5'(RANGE);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  // Window index (0..2*RANGE) to signed offset around the window centre.
  function automatic logic signed [4:0] idx_to_mv(input logic [3:0] idx);
    logic signed [4:0] v;
    v = $signed({1'b0, idx}) - OFFS;
    return v;
  endfunction

  state_t                   r_state;
  state_t                   w_next_state;
  logic [3:0]               r_x;
  logic [3:0]               r_y;
  logic [DATA_W-1:0]        r_run_best_p0;
  logic [3:0]               r_bx_p0;
  logic [3:0]               r_by_p0;
  logic                     r_vld_p1;
  logic [DATA_W-1:0]        r_best_sad_p1;
  logic signed [4:0]        r_mv_x_p1;
  logic signed [4:0]        r_mv_y_p1;

  logic                     w_accept;
  logic                     w_first;
  logic                     w_last;
  logic                     w_take;
  logic [DATA_W-1:0]        w_new_best;
  logic [3:0]               w_new_bx;
  logic [3:0]               w_new_by;

  // A candidate is consumed only while scanning with mad_valid high.
  assign w_accept = (r_state == S_SCAN) && s_if.mad_valid;
  assign w_first  = (r_x == 4'd0) && (r_y == 4'd0);
  assign w_last   = (r_x == LAST) && (r_y == LAST);

  // First candidate always loads (so 12'hFFF is captured); later ones only on
  // strictly smaller SAD, which keeps the earliest candidate on ties.
  assign w_take     = w_first || (s_if.mad < r_run_best_p0);
  assign w_new_best = w_take ? s_if.mad : r_run_best_p0;
  assign w_new_bx   = w_take ? r_x : r_bx_p0;
  assign w_new_by   = w_take ? r_y : r_by_p0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: start is only honoured from IDLE; the last accepted
  // candidate ends the scan.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (s_if.start) w_next_state = S_SCAN;
      S_SCAN: if (w_accept && w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Raster x/y counters: cleared on start, advanced per accepted candidate,
  // wrapped back to the origin after the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= 4'd0;
      r_y <= 4'd0;
    end else if ((r_state == S_IDLE) && s_if.start) begin
      r_x <= 4'd0;
      r_y <= 4'd0;
    end else if (w_accept) begin
      if (w_last) begin
        r_x <= 4'd0;
        r_y <= 4'd0;
      end else if (r_x == LAST) begin
        r_x <= 4'd0;
        r_y <= r_y + 4'd1;
      end else begin
        r_x <= r_x + 4'd1;
      end
    end
  end

  // ---- stage p0: running minimum (data only, first candidate reinitialises) ----
  // Running best SAD and its index, updated per accepted candidate.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_run_best_p0 <= w_new_best;
      r_bx_p0       <= w_new_bx;
      r_by_p0       <= w_new_by;
    end
  end

  // ---- stage p1: result registers, loaded only when a window completes ----
  // Done pulse accompanies the result load.
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= w_accept && w_last;
  end

  // Published results; held until the next completed window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best_sad_p1 <= {DATA_W{1'b1}};
      r_mv_x_p1     <= 5'sd0;
      r_mv_y_p1     <= 5'sd0;
    end else if (w_accept && w_last) begin
      r_best_sad_p1 <= w_new_best;
      r_mv_x_p1     <= idx_to_mv(w_new_bx);
      r_mv_y_p1     <= idx_to_mv(w_new_by);
    end
  end

  assign s_if.busy     = (r_state == S_SCAN);
  assign s_if.done     = r_vld_p1;
  assign s_if.best_sad = r_best_sad_p1;
  assign s_if.mv_x     = r_mv_x_p1;
  assign s_if.mv_y     = r_mv_y_p1;

endmodule

// File: tb/tb_sad_min_search.sv
// Directed bench for sad_min_search with three instances (RANGE = 1, 2, 7).
module tb_sad_min_search;

  logic clk;
  logic rst;

  sad_min_search_if if1 ();
  sad_min_search_if if2 ();
  sad_min_search_if if7 ();

  sad_min_search #(.RANGE(1)) u_r1 (.clk(clk), .rst(rst), .s_if(if1.slave));
  sad_min_search #(.RANGE(2)) u_r2 (.clk(clk), .rst(rst), .s_if(if2.slave));
  sad_min_search #(.RANGE(7)) u_r7 (.clk(clk), .rst(rst), .s_if(if7.slave));

  logic              st_d  [3];
  logic              vld_d [3];
  logic [11:0]       mad_d [3];
  logic              busy_o[3];
  logic              done_o[3];
  logic [11:0]       bs_o  [3];
  logic signed [4:0] mvx_o [3];
  logic signed [4:0] mvy_o [3];

  assign if1.start = st_d[0]; assign if1.mad_valid = vld_d[0]; assign if1.mad = mad_d[0];
  assign if2.start = st_d[1]; assign if2.mad_valid = vld_d[1]; assign if2.mad = mad_d[1];
  assign if7.start = st_d[2]; assign if7.mad_valid = vld_d[2]; assign if7.mad = mad_d[2];

  assign busy_o[0] = if1.busy; assign done_o[0] = if1.done; assign bs_o[0] = if1.best_sad;
  assign mvx_o[0]  = if1.mv_x; assign mvy_o[0]  = if1.mv_y;
  assign busy_o[1] = if2.busy; assign done_o[1] = if2.done; assign bs_o[1] = if2.best_sad;
  assign mvx_o[1]  = if2.mv_x; assign mvy_o[1]  = if2.mv_y;
  assign busy_o[2] = if7.busy; assign done_o[2] = if7.done; assign bs_o[2] = if7.best_sad;
  assign mvx_o[2]  = if7.mv_x; assign mvy_o[2]  = if7.mv_y;

  int tests;
  int fails;
  logic [11:0] vals [225];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: drive selected instance (others idle), return on the next
  // falling edge so outputs reflect the rising edge that sampled the drive.
  task automatic cyc(input int sel, input logic st, input logic v, input logic [11:0] m);
    for (int k = 0; k < 3; k++) begin
      st_d[k] = 1'b0; vld_d[k] = 1'b0; mad_d[k] = 12'd0;
    end
    st_d[sel] = st; vld_d[sel] = v; mad_d[sel] = m;
    @(negedge clk);
  endtask

  // Feed n candidates from vals[]; optional stall cycles carry mad=0 with
  // mad_valid low; start is additionally pulsed with sample start_at.
  task automatic feed(input int sel, input int n, input int stall_pat, input int start_at,
                      output int early);
    int stalls;
    early = 0;
    for (int i = 0; i < n; i++) begin
      stalls = (stall_pat != 0) ? ((i * 5 + stall_pat) % 3) : 0;
      for (int s = 0; s < stalls; s++) begin
        cyc(sel, 1'b0, 1'b0, 12'd0);
        if (done_o[sel] !== 1'b0) early = 1;
      end
      cyc(sel, (i == start_at), 1'b1, vals[i]);
      if (i < n - 1 && done_o[sel] !== 1'b0) early = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(0, 1'b0, 1'b0, 12'd0);
    cyc(0, 1'b0, 1'b0, 12'd0);
    for (int k = 0; k < 3; k++) begin
      tests++; if (busy_o[k] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b, expected 0", k, busy_o[k]); end
      tests++; if (done_o[k] !== 1'b0) begin fails++; $display("FAIL reset_done[%0d]: got %b, expected 0", k, done_o[k]); end
      tests++; if (bs_o[k] !== 12'hFFF) begin fails++; $display("FAIL reset_best[%0d]: got %h, expected fff", k, bs_o[k]); end
      tests++; if (mvx_o[k] !== 5'sd0) begin fails++; $display("FAIL reset_mvx[%0d]: got %0d, expected 0", k, mvx_o[k]); end
      tests++; if (mvy_o[k] !== 5'sd0) begin fails++; $display("FAIL reset_mvy[%0d]: got %0d, expected 0", k, mvy_o[k]); end
    end
    rst = 1'b0;
    cyc(0, 1'b0, 1'b0, 12'd0);
  endtask

  task automatic test_decreasing();
    int early;
    for (int i = 0; i < 9; i++) vals[i] = 12'(900 - 100 * i);
    cyc(0, 1'b1, 1'b0, 12'd0);
    tests++; if (busy_o[0] !== 1'b1) begin fails++; $display("FAIL dec_busy_start: got %b, expected 1", busy_o[0]); end
    feed(0, 9, 0, -1, early);
    tests++; if (early != 0) begin fails++; $display("FAIL dec_early_done: got %0d, expected 0", early); end
    tests++; if (done_o[0] !== 1'b1) begin fails++; $display("FAIL dec_done: got %b, expected 1", done_o[0]); end
    tests++; if (busy_o[0] !== 1'b0) begin fails++; $display("FAIL dec_busy_end: got %b, expected 0", busy_o[0]); end
    tests++; if (bs_o[0] !== 12'd100) begin fails++; $display("FAIL dec_best: got %0d, expected 100", bs_o[0]); end
    tests++; if (mvx_o[0] !== 5'sd1) begin fails++; $display("FAIL dec_mvx: got %0d, expected 1", mvx_o[0]); end
    tests++; if (mvy_o[0] !== 5'sd1) begin fails++; $display("FAIL dec_mvy: got %0d, expected 1", mvy_o[0]); end
    cyc(0, 1'b0, 1'b0, 12'd0);
    tests++; if (done_o[0] !== 1'b0) begin fails++; $display("FAIL dec_done_pulse: got %b, expected 0", done_o[0]); end
    tests++; if (bs_o[0] !== 12'd100) begin fails++; $display("FAIL dec_best_hold: got %0d, expected 100", bs_o[0]); end
  endtask

  task automatic test_tie();
    int early;
    for (int i = 0; i < 9; i++) vals[i] = 12'hFFF;
    vals[3] = 12'd50;
    vals[7] = 12'd50;
    cyc(0, 1'b1, 1'b0, 12'd0);
    feed(0, 9, 0, -1, early);
    tests++; if (early != 0) begin fails++; $display("FAIL tie_early_done: got %0d, expected 0", early); end
    tests++; if (done_o[0] !== 1'b1) begin fails++; $display("FAIL tie_done: got %b, expected 1", done_o[0]); end
    tests++; if (bs_o[0] !== 12'd50) begin fails++; $display("FAIL tie_best: got %0d, expected 50", bs_o[0]); end
    tests++; if (mvx_o[0] !== -5'sd1) begin fails++; $display("FAIL tie_mvx: got %0d, expected -1", mvx_o[0]); end
    tests++; if (mvy_o[0] !== 5'sd0) begin fails++; $display("FAIL tie_mvy: got %0d, expected 0", mvy_o[0]); end
    cyc(0, 1'b0, 1'b0, 12'd0);
  endtask

  task automatic test_all_max();
    int early;
    for (int i = 0; i < 225; i++) vals[i] = 12'hFFF;
    cyc(2, 1'b1, 1'b0, 12'd0);
    feed(2, 225, 0, -1, early);
    tests++; if (early != 0) begin fails++; $display("FAIL max_early_done: got %0d, expected 0", early); end
    tests++; if (done_o[2] !== 1'b1) begin fails++; $display("FAIL max_done: got %b, expected 1", done_o[2]); end
    tests++; if (bs_o[2] !== 12'hFFF) begin fails++; $display("FAIL max_best: got %h, expected fff", bs_o[2]); end
    tests++; if (mvx_o[2] !== -5'sd7) begin fails++; $display("FAIL max_mvx: got %0d, expected -7", mvx_o[2]); end
    tests++; if (mvy_o[2] !== -5'sd7) begin fails++; $display("FAIL max_mvy: got %0d, expected -7", mvy_o[2]); end
    cyc(2, 1'b0, 1'b0, 12'd0);
  endtask

  // RANGE=2 window: min 17 at index 4 (x=4,y=0); a later 17 at index 20 must lose.
  task automatic load_stall_vals();
    for (int i = 0; i < 25; i++) vals[i] = 12'(100 + 3 * i);
    vals[4]  = 12'd17;
    vals[20] = 12'd17;
  endtask

  task automatic test_stalls();
    int early;
    load_stall_vals();
    cyc(1, 1'b1, 1'b0, 12'd0);
    feed(1, 25, 1, -1, early);
    tests++; if (early != 0) begin fails++; $display("FAIL stall_early_done: got %0d, expected 0", early); end
    tests++; if (done_o[1] !== 1'b1) begin fails++; $display("FAIL stall_done: got %b, expected 1", done_o[1]); end
    tests++; if (busy_o[1] !== 1'b0) begin fails++; $display("FAIL stall_busy: got %b, expected 0", busy_o[1]); end
    tests++; if (bs_o[1] !== 12'd17) begin fails++; $display("FAIL stall_best: got %0d, expected 17", bs_o[1]); end
    tests++; if (mvx_o[1] !== 5'sd2) begin fails++; $display("FAIL stall_mvx: got %0d, expected 2", mvx_o[1]); end
    tests++; if (mvy_o[1] !== -5'sd2) begin fails++; $display("FAIL stall_mvy: got %0d, expected -2", mvy_o[1]); end
    cyc(1, 1'b0, 1'b0, 12'd0);
  endtask

  task automatic test_reset_mid();
    int early;
    for (int i = 0; i < 25; i++) vals[i] = 12'd5;
    cyc(1, 1'b1, 1'b0, 12'd0);
    feed(1, 10, 0, -1, early);
    tests++; if (early != 0 || done_o[1] !== 1'b0) begin fails++; $display("FAIL mid_no_done: got %b, expected 0", done_o[1]); end
    rst = 1'b1;
    cyc(1, 1'b0, 1'b1, 12'd5);
    rst = 1'b0;
    tests++; if (busy_o[1] !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b, expected 0", busy_o[1]); end
    tests++; if (done_o[1] !== 1'b0) begin fails++; $display("FAIL mid_done: got %b, expected 0", done_o[1]); end
    tests++; if (bs_o[1] !== 12'hFFF) begin fails++; $display("FAIL mid_best: got %h, expected fff", bs_o[1]); end
    tests++; if (mvx_o[1] !== 5'sd0) begin fails++; $display("FAIL mid_mvx: got %0d, expected 0", mvx_o[1]); end
    tests++; if (mvy_o[1] !== 5'sd0) begin fails++; $display("FAIL mid_mvy: got %0d, expected 0", mvy_o[1]); end
    for (int k = 0; k < 15; k++) begin
      cyc(1, 1'b0, 1'b1, 12'd5);
      tests++; if (done_o[1] !== 1'b0) begin fails++; $display("FAIL mid_late_done: got %b, expected 0", done_o[1]); end
    end
    load_stall_vals();
    cyc(1, 1'b1, 1'b0, 12'd0);
    feed(1, 25, 2, -1, early);
    tests++; if (early != 0) begin fails++; $display("FAIL mid2_early_done: got %0d, expected 0", early); end
    tests++; if (done_o[1] !== 1'b1) begin fails++; $display("FAIL mid2_done: got %b, expected 1", done_o[1]); end
    tests++; if (bs_o[1] !== 12'd17) begin fails++; $display("FAIL mid2_best: got %0d, expected 17", bs_o[1]); end
    tests++; if (mvx_o[1] !== 5'sd2) begin fails++; $display("FAIL mid2_mvx: got %0d, expected 2", mvx_o[1]); end
    tests++; if (mvy_o[1] !== -5'sd2) begin fails++; $display("FAIL mid2_mvy: got %0d, expected -2", mvy_o[1]); end
    cyc(1, 1'b0, 1'b0, 12'd0);
  endtask

  task automatic test_ignored();
    int early;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1'b0, 1'b1, 12'd0);
      tests++; if (busy_o[0] !== 1'b0) begin fails++; $display("FAIL ign_idle_busy: got %b, expected 0", busy_o[0]); end
    end
    vals[0] = 12'd500; vals[1] = 12'd400; vals[2] = 12'd300;
    vals[3] = 12'd200; vals[4] = 12'd250; vals[5] = 12'd350;
    vals[6] = 12'd450; vals[7] = 12'd550; vals[8] = 12'd650;
    cyc(0, 1'b1, 1'b1, 12'd0);
    feed(0, 9, 0, 5, early);
    tests++; if (early != 0) begin fails++; $display("FAIL ign_early_done: got %0d, expected 0", early); end
    tests++; if (done_o[0] !== 1'b1) begin fails++; $display("FAIL ign_done: got %b, expected 1", done_o[0]); end
    tests++; if (bs_o[0] !== 12'd200) begin fails++; $display("FAIL ign_best: got %0d, expected 200", bs_o[0]); end
    tests++; if (mvx_o[0] !== -5'sd1) begin fails++; $display("FAIL ign_mvx: got %0d, expected -1", mvx_o[0]); end
    tests++; if (mvy_o[0] !== 5'sd0) begin fails++; $display("FAIL ign_mvy: got %0d, expected 0", mvy_o[0]); end
  endtask

  task automatic test_back_to_back();
    int early;
    for (int i = 0; i < 9; i++) vals[i] = 12'(900 - 100 * i);
    cyc(0, 1'b1, 1'b0, 12'd0);
    feed(0, 9, 0, 8, early);
    tests++; if (done_o[0] !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b, expected 1", done_o[0]); end
    tests++; if (busy_o[0] !== 1'b0) begin fails++; $display("FAIL b2b_busy_done: got %b, expected 0", busy_o[0]); end
    tests++; if (bs_o[0] !== 12'd100) begin fails++; $display("FAIL b2b_best: got %0d, expected 100", bs_o[0]); end
    cyc(0, 1'b0, 1'b0, 12'd0);
    tests++; if (busy_o[0] !== 1'b0) begin fails++; $display("FAIL b2b_busy_after: got %b, expected 0", busy_o[0]); end
    tests++; if (done_o[0] !== 1'b0) begin fails++; $display("FAIL b2b_done_after: got %b, expected 0", done_o[0]); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      st_d[k] = 1'b0; vld_d[k] = 1'b0; mad_d[k] = 12'd0;
    end
    test_reset();
    test_decreasing();
    test_tie();
    test_all_max();
    test_stalls();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
